// File: rtl/instr_encoder.sv
// MIPS instruction encoder feeding a 4-deep word FIFO toward instruction memory.
// Optional INSTR_ENCODER_CHECK_EN: drop illegal kinds (10-15) and raise a sticky err flag.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [25:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_addr,
    output logic [31:0] out_data,
    output logic [2:0]  level,
    output logic        err
);

    logic [31:0] mem_q [4];
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [2:0]  cnt_q;
    logic [7:0]  addr_q;
    logic [31:0] word;
    logic        accept;
    logic        enq_ok;
    logic        push;
    logic        pop;

    always_comb begin
        word = 32'h0000_0000;
        case (in_kind)
            4'd0:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            4'd1:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            4'd2:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            4'd3:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            4'd4:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            4'd5:    word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            4'd6:    word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            4'd7:    word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            4'd8:    word = {6'b001000, in_rs, in_rt, in_imm[15:0]};
            4'd9:    word = {6'b000010, in_imm};
            default: word = 32'h0000_0000;
        endcase
    end

    assign in_ready  = (cnt_q != 3'd4);
    assign out_valid = (cnt_q != 3'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_addr  = addr_q;
    assign level     = cnt_q;

    // clr blocks both sides of the handshake; in_ready still shows the pre-clear level.
    assign accept = in_valid & in_ready & ~clr;
    assign push   = accept & enq_ok;
    assign pop    = out_valid & out_ready & ~clr;

`ifdef INSTR_ENCODER_CHECK_EN
    logic illegal;
    logic err_q;

    assign illegal = (in_kind > 4'd9);
    assign enq_ok  = ~illegal;
    assign err     = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (clr) begin
            err_q <= 1'b0;
        end else if (accept && illegal) begin
            err_q <= 1'b1;
        end
    end
`else
    assign enq_ok = 1'b1;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
            addr_q   <= 8'd0;
        end else if (clr) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
            addr_q   <= 8'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= word;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
                addr_q   <= addr_q + 8'd1;
            end
            cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus random traffic vs a queue model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [25:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [31:0] out_data;
    logic [2:0]  level;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mq[$];
    logic [7:0]  maddr = 8'd0;
    logic        merr = 1'b0;
    logic        wrap_seen = 1'b0;

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .level     (level),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoding built arithmetically from the field layout of a MIPS word.
    function automatic logic [31:0] ref_word(input int k, input int rs, input int rt,
                                             input int rd, input int imm);
        int unsigned functs[5] = '{32, 34, 36, 37, 42};
        int unsigned ops[4]    = '{35, 43, 4, 8};
        int unsigned w;
        if (k <= 4) begin
            w = (rs << 21) + (rt << 16) + (rd << 11) + functs[k];
        end else if (k <= 8) begin
            w = (ops[k-5] << 26) + (rs << 21) + (rt << 16) + (imm % 65536);
        end else if (k == 9) begin
            w = (2 << 26) + (imm % (1 << 26));
        end else begin
            w = 0;
        end
        return w;
    endfunction

    task automatic check_state();
        check_eq("level", {29'd0, level}, mq.size());
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != 4});
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        check_eq("out_addr", {24'd0, out_addr}, {24'd0, maddr});
        check_eq("err", {31'd0, err}, {31'd0, merr});
        if (mq.size() != 0) check_eq("out_data", out_data, mq[0]);
    endtask

    // Called at a negedge: drive inputs, advance one clock, update model, check outputs.
    task automatic step(input int v, input int k, input int rs, input int rt, input int rd,
                        input int imm, input int ordy, input int c);
        logic acc;
        logic popd;
        logic legal;
        in_valid  = (v != 0);
        in_kind   = 4'(k);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 26'(imm);
        out_ready = (ordy != 0);
        clr       = (c != 0);
        acc   = (v != 0) && (mq.size() != 4);
        popd  = (ordy != 0) && (mq.size() != 0);
        legal = (k <= 9);
        @(posedge clk);
        if (c != 0) begin
            mq.delete();
            maddr = 8'd0;
            merr  = 1'b0;
        end else begin
            if (popd) begin
                void'(mq.pop_front());
                if (maddr == 8'd255) wrap_seen = 1'b1;
                maddr = maddr + 8'd1;
            end
            if (acc) begin
`ifdef INSTR_ENCODER_CHECK_EN
                if (legal) mq.push_back(ref_word(k, rs, rt, rd, imm));
                else merr = 1'b1;
`else
                mq.push_back(legal ? ref_word(k, rs, rt, rd, imm) : 32'h0);
`endif
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic idle(input int ordy);
        step(0, 0, 0, 0, 0, 0, ordy, 0);
    endtask

    initial begin
        reset = 1'b1;
        clr = 1'b0; in_valid = 1'b0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_state();
        check_eq("rst_data", out_data, 32'h0);
        reset = 1'b0;

        // Single ADD, then its pop advances the address.
        step(1, 0, 1, 2, 3, 0, 1, 0);
        check_eq("add_word", out_data, 32'h0022_1820);
        idle(1);
        check_eq("add_addr_after", {24'd0, out_addr}, 32'd1);

        // LW, BEQ, J back-to-back with memory stalled, then drained.
        step(1, 5, 0, 2, 0, 'h50, 0, 0);
        step(1, 7, 3, 7, 0, 'h000A, 0, 0);
        step(1, 9, 0, 0, 0, 'h11, 0, 0);
        check_eq("lw_word", out_data, 32'h8C02_0050);
        idle(1);
        check_eq("beq_word", out_data, 32'h1067_000A);
        idle(1);
        check_eq("j_word", out_data, 32'h0800_0011);
        idle(1);

        // Backpressure: 5 requests into a stalled queue, 5th waits for first pop.
        for (int i = 0; i < 5; i++) step(1, 8, i, i + 1, 0, 100 + i, 0, 0);
        check_eq("full_level", {29'd0, level}, 32'd4);
        check_eq("full_ready", {31'd0, in_ready}, 32'd0);
        step(1, 8, 9, 9, 0, 999, 1, 0);
        step(1, 8, 9, 9, 0, 999, 1, 0);
        for (int i = 0; i < 5; i++) idle(1);

        // Illegal kind.
        step(1, 12, 1, 1, 1, 1, 0, 0);
        idle(1);
        step(1, 0, 4, 5, 6, 0, 0, 0);
        step(1, 14, 1, 1, 1, 1, 1, 0);
        idle(1);

        // Clear with simultaneous push and pop.
        step(1, 1, 1, 2, 3, 0, 0, 0);
        step(1, 2, 4, 5, 6, 0, 0, 0);
        step(1, 3, 7, 8, 9, 0, 1, 1);
        check_eq("clr_level", {29'd0, level}, 32'd0);

        // Sustained random traffic; enough pops to wrap the address.
        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(0, 9) != 0) ? 1 : 0, $urandom_range(0, 15),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 int'($urandom_range(0, 32'h03FF_FFFF)), ($urandom_range(0, 7) != 0) ? 1 : 0, 0);
        end
        check_eq("addr_wrap_seen", {31'd0, wrap_seen}, 32'd1);

        // Asynchronous reset with three words queued.
        for (int i = 0; i < 4; i++) idle(1);
        for (int i = 0; i < 3; i++) step(1, 4, i, i, i, 0, 0, 0);
        check_eq("pre_rst_level", {29'd0, level}, 32'd3);
        #2 reset = 1'b1;
        #1;
        mq.delete();
        maddr = 8'd0;
        merr  = 1'b0;
        check_state();
        check_eq("rst_mid_data", out_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 1, 2, 3, 0, 0, 0);
        idle(1);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: clr  input  1  synchronous clear: flush queue, zero address and error state.
REQ-004 SHALL have port: in_valid  input  1  instruction request present.
REQ-005 SHALL have port: in_ready  output  1  request accepted when in_valid & in_ready at a clock edge.
REQ-006 SHALL have port: in_kind  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J, 10-15 illegal.
REQ-007 SHALL have ports: in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-008 SHALL have port: in_imm  input  26  immediate; bits [15:0] for I-type, [25:0] for J.
REQ-009 SHALL have port: out_valid  output  1  encoded word available for instruction-memory write.
REQ-010 SHALL have port: out_ready  input  1  memory accepts word when out_valid & out_ready.
REQ-011 SHALL have ports: out_addr  output  8  word address; out_data  output  32  encoded MIPS word.
REQ-012 SHALL have ports: level  output  3  queue occupancy 0-4; err  output  1  sticky illegal-kind flag.

Function
REQ-013 SHALL encode R-type (kinds 0-4) as op=000000, rs, rt, rd, shamt=00000, funct = 100000/100010/100100/100101/101010 respectively.
REQ-014 SHALL encode LW/SW/BEQ/ADDI as op = 100011/101011/000100/001000, fields [25:21]=rs, [20:16]=rt, [15:0]=in_imm[15:0].
REQ-015 SHALL encode J as op=000010, [25:0]=in_imm[25:0]; unused input fields ignored.
REQ-016 SHALL encode at acceptance and store the 32-bit word in a 4-entry FIFO with rd/wr pointers (2 bits) and occupancy counter.
REQ-017 SHALL drive in_ready = (level != 4); no push when full regardless of a same-cycle pop.
REQ-018 SHALL drive out_valid = (level != 0); out_data = FIFO head; minimum latency acceptance-to-out_valid 1 cycle.
REQ-019 SHALL hold out_data and out_addr stable while out_valid & !out_ready.
REQ-020 SHALL, on each pop (out_valid & out_ready), advance out_addr by 1, wrapping 255 -> 0.
REQ-021 SHALL support simultaneous push and pop when 0 < level < 4: level unchanged, both pointers advance.
REQ-022 SHALL preserve word order: words written in acceptance order at consecutive addresses.
REQ-023 SHALL give clr priority over push and pop in the same cycle: level 0, pointers 0, out_addr 0, err 0; request presented that cycle is not accepted (in_ready still reflects pre-clear level).

Reset
REQ-024 SHALL on reset asserted: level 0, out_valid 0, out_addr 0, out_data 0x00000000, err 0, in_ready 1, FIFO storage zeroed.
REQ-025 SHALL on reset asserted mid-transfer discard all queued words; no write is completed after reset.
REQ-026 SHALL resume accepting requests the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL recognise macro INSTR_ENCODER_CHECK_EN.
REQ-028 SHALL with INSTR_ENCODER_CHECK_EN defined: accept kinds 10-15 (handshake completes), not enqueue them, set err (sticky until reset or clr).
REQ-029 SHALL without INSTR_ENCODER_CHECK_EN: enqueue kinds 10-15 as NOP 0x00000000; err tied 0.

Verification
REQ-030 SHALL test: ADD rs=1 rt=2 rd=3, out_ready=1 -> next cycle out_valid=1, out_data=0x00221820, out_addr=0; then out_addr=1.
REQ-031 SHALL test: LW rs=0 rt=2 imm=0x50, BEQ rs=3 rt=7 imm=0x000A, J imm=0x0000011 back-to-back -> 0x8C020050, 0x1067000A, 0x08000011 at addrs 0,1,2.
REQ-032 SHALL test: out_ready=0, 5 requests -> 4 accepted, in_ready=0, level=4; release out_ready -> 4 words in order, 5th accepted after first pop.
REQ-033 SHALL test: 256 pops with continuous traffic -> out_addr wraps 255 -> 0.
REQ-034 SHALL test: kind=12 -> with macro err=1 and level unchanged; without macro out_data=0x00000000 written.
REQ-035 SHALL test: reset asserted with level=3 -> immediately out_valid=0, level=0, out_addr=0; clr with simultaneous push and pop -> same cleared state, no word accepted.
